// File: rtl/event_unit_pkg.sv
// Shared types for the event unit: dispatcher FSM states
// and a small sizing helper for the holdoff counter.
package event_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CLEAR   = 2'd2,
        HOLDOFF = 2'd3
    } disp_state_e;

    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_find_first.sv
// Round-robin priority search: first set bit of vec_i at or
// above start_i, wrapping from N-1 back to 0.
module rr_find_first #(
    parameter  int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic         valid_o,
    output logic [W-1:0] index_o
);

    int idx;

    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start_i) + i) % N;
            if (!valid_o && vec_i[idx]) begin
                valid_o = 1'b1;
                index_o = W'(idx);
            end
        end
    end

endmodule

// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: round-robin picks one pending line,
// requests the core, pulses a clear on ack, then holds off.
module irq_dispatcher
    import event_unit_pkg::*;
#(
    parameter  int NUM_LINES      = 32,
    parameter  int HOLDOFF_CYCLES = 4,
    localparam int ID_W           = $clog2(NUM_LINES)
) (
    input  logic                 clk_i,
    input  logic                 HRESETn,
    input  logic [NUM_LINES-1:0] pending_i,
    input  logic                 enable_i,
    output logic                 irq_req_o,
    output logic [ID_W-1:0]      irq_id_o,
    input  logic                 irq_ack_i,
    input  logic [ID_W-1:0]      irq_ack_id_i,
    output logic [NUM_LINES-1:0] clr_o,
    output logic                 busy_o
);

    localparam int CNT_W = cnt_width(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [ID_W-1:0]  ID_MAX    = ID_W'(NUM_LINES - 1);

    disp_state_e          state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic [NUM_LINES-1:0] clr_q, clr_d;

    logic            hit;
    logic [ID_W-1:0] sel;

    rr_find_first #(.N(NUM_LINES)) u_find (
        .vec_i   (pending_i),
        .start_i (ptr_q),
        .valid_o (hit),
        .index_o (sel)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i && hit) begin
                    state_d = REQ;
                    id_d    = sel;
                end
            end
            REQ: begin
                // a matching ack beats a withdrawal in the same cycle
                if (irq_ack_i && (irq_ack_id_i == id_q)) begin
                    state_d = CLEAR;
                end else if (!pending_i[id_q] || !enable_i) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                ptr_d = (id_q == ID_MAX) ? '0 : id_q + 1'b1;
                if (HOLDOFF_CYCLES > 0) begin
                    state_d = HOLDOFF;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
        clr_d  = '0;
        if (state_d == CLEAR) begin
            clr_d[id_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
        end
    end

    assign irq_req_o = req_q;
    assign irq_id_o  = id_q;
    assign clr_o     = clr_q;
    assign busy_o    = busy_q;

endmodule
